// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: game states, directions,
// BCD digit type and small direction helpers.
package snake_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_NINE = 4'd9;

    // Up/down and left/right differ only in bit 0 of the encoding.
    function automatic logic [1:0] dir_reverse(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    function automatic logic move_valid(input logic [3:0] m);
        return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] move_to_dir(input logic [3:0] m);
        case (m)
            4'b1000: return DIR_UP;
            4'b0100: return DIR_DOWN;
            4'b0010: return DIR_LEFT;
            default: return DIR_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/snake_score_bcd.sv
// Four-digit BCD incrementer with decimal carry that saturates at 9999.
module snake_score_bcd
    import snake_pkg::*;
(
    input  logic [15:0] score_i,
    output logic [15:0] score_o
);

    logic carry;

    // NOTE: blocking assignments with a default for every output at the top of
    // always_comb keep the ripple carry ordered and prevent latch inference.
    always_comb begin
        score_o = score_i;
        carry   = 1'b1;
        if (score_i != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (bcd_digit_t'(score_i[4*i +: 4]) == BCD_NINE) begin
                        score_o[4*i +: 4] = 4'd0;
                    end else begin
                        score_o[4*i +: 4] = score_i[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: step timing, direction commit, BCD scoring.
// Optional build macro SNAKE_SPEEDUP_EN shortens the step period per food eaten.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int STEP_CYCLES     = 5000000,
    parameter int MIN_STEP_CYCLES = 1000000,
    parameter int SPEEDUP_DELTA   = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  move,
    input  logic        ate,
    input  logic        collide,
    output logic        step,
    output logic        clear,
    output logic [1:0]  dir,
    output logic [1:0]  state,
    output logic [15:0] score
);

    // Counter width covers every period value any parameter can produce.
    localparam int MAX_A = (STEP_CYCLES > MIN_STEP_CYCLES) ? STEP_CYCLES : MIN_STEP_CYCLES;
    localparam int MAX_C = (MAX_A > SPEEDUP_DELTA) ? MAX_A : SPEEDUP_DELTA;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] PERIOD_INIT = CW'(STEP_CYCLES);

    logic [1:0]    state_q, state_d;
    logic          step_q, step_d;
    logic          clear_q, clear_d;
    logic [1:0]    dir_q, dir_d;
    logic [15:0]   score_q, score_d, score_inc;
    logic          pend_valid_q, pend_valid_d;
    logic [1:0]    pend_dir_q, pend_dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] wrap_at;
    logic [1:0]    move_dir;
    logic          move_ok;

`ifdef SNAKE_SPEEDUP_EN
    localparam logic [CW-1:0] MIN_PERIOD = CW'(MIN_STEP_CYCLES);
    localparam logic [CW-1:0] DELTA      = CW'(SPEEDUP_DELTA);

    // period_q is the target; live_q is what the counter runs against and only
    // picks up the target at a wrap so a period in progress is never cut short.
    logic [CW-1:0] period_q, period_d, live_q, live_d, period_dec;

    assign period_dec = ((period_q - MIN_PERIOD) >= DELTA) ? (period_q - DELTA) : MIN_PERIOD;
    assign wrap_at    = live_q - CW'(1);
`else
    assign wrap_at = PERIOD_INIT - CW'(1);
`endif

    assign move_dir = move_to_dir(move);
    assign move_ok  = move_valid(move) && (move_dir != dir_reverse(dir_q));

    snake_score_bcd u_score_bcd (
        .score_i (score_q),
        .score_o (score_inc)
    );

    always_comb begin
        state_d      = state_q;
        step_d       = 1'b0;
        clear_d      = 1'b0;
        dir_d        = dir_q;
        score_d      = score_q;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        cnt_d        = cnt_q;
`ifdef SNAKE_SPEEDUP_EN
        period_d     = period_q;
        live_d       = live_q;
`endif
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d      = ST_PLAY;
                    clear_d      = 1'b1;
                    score_d      = 16'h0000;
                    cnt_d        = '0;
                    pend_valid_d = 1'b0;
                    pend_dir_d   = DIR_UP;
                    dir_d        = DIR_RIGHT;
`ifdef SNAKE_SPEEDUP_EN
                    period_d     = PERIOD_INIT;
                    live_d       = PERIOD_INIT;
`endif
                end
            end
            ST_PLAY: begin
                // A collision overrides every other event in the same cycle.
                if (collide) begin
                    state_d = ST_OVER;
                end else begin
                    if (ate) begin
                        score_d  = score_inc;
`ifdef SNAKE_SPEEDUP_EN
                        period_d = period_dec;
`endif
                    end
                    if (move_ok) begin
                        pend_valid_d = 1'b1;
                        pend_dir_d   = move_dir;
                    end
                    if (cnt_q == wrap_at) begin
                        step_d = 1'b1;
                        cnt_d  = '0;
                        if (pend_valid_d) begin
                            dir_d = pend_dir_d;
                        end
                        pend_valid_d = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
                        live_d = period_d;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (start) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_q       <= 1'b0;
            clear_q      <= 1'b0;
            dir_q        <= DIR_RIGHT;
            score_q      <= 16'h0000;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_UP;
            cnt_q        <= '0;
`ifdef SNAKE_SPEEDUP_EN
            period_q     <= PERIOD_INIT;
            live_q       <= PERIOD_INIT;
`endif
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            clear_q      <= clear_d;
            dir_q        <= dir_d;
            score_q      <= score_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            cnt_q        <= cnt_d;
`ifdef SNAKE_SPEEDUP_EN
            period_q     <= period_d;
            live_q       <= live_d;
`endif
        end
    end

    assign step  = step_q;
    assign clear = clear_q;
    assign dir   = dir_q;
    assign state = state_q;
    assign score = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios plus random
// stimulus compared every cycle against a behavioural game model.
module tb_snake_game_ctrl;

    localparam int STEP  = 8;
    localparam int MINP  = 4;
    localparam int DELTA = 2;
`ifdef SNAKE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  move = 4'd0;
    logic        ate = 1'b0;
    logic        collide = 1'b0;
    logic        step, clear;
    logic [1:0]  dir, state;
    logic [15:0] score;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .STEP_CYCLES     (STEP),
        .MIN_STEP_CYCLES (MINP),
        .SPEEDUP_DELTA   (DELTA)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .move    (move),
        .ate     (ate),
        .collide (collide),
        .step    (step),
        .clear   (clear),
        .dir     (dir),
        .state   (state),
        .score   (score)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 play, 2 pause, 3 over; dir 0 up,1 down,2 left,3 right.
    int m_state, m_dir, m_score, m_pend, m_cnt, m_live, m_next;
    bit m_step, m_clear;
    bit obs_step, obs_clear;

    function automatic int dir_of(input logic [3:0] mv);
        if ($countones(mv) != 1) return -1;
        if (mv[3]) return 0;
        if (mv[2]) return 1;
        if (mv[1]) return 2;
        return 3;
    endfunction

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_dir = 3; m_score = 0; m_pend = -1; m_cnt = 0;
        m_live = STEP; m_next = STEP; m_step = 0; m_clear = 0;
    endtask

    task automatic model_update(input bit s, input logic [3:0] mv, input bit a, input bit c);
        int d;
        m_step  = 0;
        m_clear = 0;
        case (m_state)
            0, 3: if (s) begin
                m_state = 1; m_clear = 1; m_score = 0; m_cnt = 0; m_pend = -1;
                m_dir = 3; m_live = STEP; m_next = STEP;
            end
            1: begin
                if (c) begin
                    m_state = 3;
                end else begin
                    if (a) begin
                        m_score = (m_score < 9999) ? m_score + 1 : 9999;
                        if (SPEEDUP) m_next = (m_next - DELTA < MINP) ? MINP : m_next - DELTA;
                    end
                    d = dir_of(mv);
                    if (d >= 0 && d != opposite(m_dir)) m_pend = d;
                    m_cnt++;
                    if (m_cnt == m_live) begin
                        m_step = 1;
                        m_cnt  = 0;
                        if (m_pend >= 0) m_dir = m_pend;
                        m_pend = -1;
                        m_live = m_next;
                    end
                    if (s) m_state = 2;
                end
            end
            default: if (s) m_state = 1;
        endcase
    endtask

    // Check outputs at the falling edge, then drive the inputs for the next rising edge.
    task automatic run_cycle(input bit s, input logic [3:0] mv, input bit a, input bit c);
        @(negedge clk);
        check("state", 32'(state), 32'(m_state));
        check("step",  32'(step),  32'(m_step));
        check("clear", 32'(clear), 32'(m_clear));
        check("dir",   32'(dir),   32'(m_dir));
        check("score", 32'(score), 32'(to_bcd(m_score)));
        obs_step  = step;
        obs_clear = clear;
        start = s; move = mv; ate = a; collide = c;
        if (!rst) model_update(s, mv, a, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 0; move = 0; ate = 0; collide = 0;
        rst = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_step",  32'(step),  32'd0);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_dir",   32'(dir),   32'd3);
        check("rst_score", 32'(score), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int idx_clear, idx_s1, idx_s2, n_steps, seen;
        int idx[5];
        int n_idx, sent;
        bit a_next;
        int exp_gap[4];
        logic [15:0] score_before;

        model_reset();
        do_reset();

        // Start: clear pulse, first step STEP cycles later, then every STEP cycles.
        run_cycle(1, 4'd0, 0, 0);
        idx_clear = -1; idx_s1 = -1; idx_s2 = -1;
        for (int k = 1; k <= 20; k++) begin
            run_cycle(0, 4'd0, 0, 0);
            if (obs_clear) idx_clear = k;
            if (obs_step) begin
                if (idx_s1 < 0) idx_s1 = k;
                else if (idx_s2 < 0) idx_s2 = k;
            end
        end
        check("play_state", 32'(state), 32'd1);
        check("first_step_gap", 32'(idx_s1 - idx_clear), 32'd8);
        check("step_period", 32'(idx_s2 - idx_s1), 32'd8);

        // Left is a reversal of right and is dropped; up commits at the next step.
        run_cycle(0, 4'b0010, 0, 0);
        run_cycle(0, 4'b1000, 0, 0);
        seen = 0;
        for (int k = 0; k < 12 && seen == 0; k++) begin
            run_cycle(0, 4'd0, 0, 0);
            if (obs_step) seen = 1;
        end
        check("step_seen", 32'(seen), 32'd1);
        check("reversal_dir", 32'(dir), 32'd0);

        // Pause for 20 cycles, then resume from the frozen count.
        run_cycle(0, 4'd0, 0, 0);
        run_cycle(0, 4'd0, 0, 0);
        run_cycle(1, 4'd0, 0, 0);
        n_steps = 0;
        for (int k = 0; k < 20; k++) begin
            run_cycle(0, 4'b0100, 1, 1);
            if (k > 0 && obs_step) n_steps++;
        end
        check("steps_in_pause", 32'(n_steps), 32'd0);
        check("pause_state", 32'(state), 32'd2);
        run_cycle(1, 4'd0, 0, 0);
        for (int k = 0; k < 20; k++) run_cycle(0, 4'd0, 0, 0);

        // ate and collide together: game over, score held, no more steps.
        run_cycle(0, 4'd0, 1, 0);
        run_cycle(0, 4'd0, 0, 0);
        score_before = to_bcd(m_score);
        run_cycle(0, 4'd0, 1, 1);
        n_steps = 0;
        for (int k = 0; k < 20; k++) begin
            run_cycle(0, 4'b1000, 1, 0);
            if (obs_step) n_steps++;
        end
        check("over_state", 32'(state), 32'd3);
        check("over_score", 32'(score), 32'(score_before));
        check("over_steps", 32'(n_steps), 32'd0);

        // start and collide together in PLAY: collide wins.
        run_cycle(1, 4'd0, 0, 0);
        for (int k = 0; k < 5; k++) run_cycle(0, 4'd0, 0, 0);
        run_cycle(1, 4'd0, 0, 1);
        run_cycle(0, 4'd0, 0, 0);
        check("start_collide", 32'(state), 32'd3);

        // Period sequence with one ate per period.
        exp_gap = SPEEDUP ? '{8, 6, 4, 4} : '{8, 8, 8, 8};
        run_cycle(1, 4'd0, 0, 0);
        n_idx = 0; sent = 0; a_next = 0;
        for (int k = 1; k <= 60 && n_idx < 5; k++) begin
            run_cycle(0, 4'd0, a_next, 0);
            if (a_next) sent++;
            a_next = 0;
            if (obs_clear) begin
                idx[n_idx] = k; n_idx++; a_next = 1;
            end else if (obs_step) begin
                idx[n_idx] = k; n_idx++;
                if (sent < 3) a_next = 1;
            end
        end
        check("period_marks", 32'(n_idx), 32'd5);
        for (int i = 0; i < 4; i++) check($sformatf("period_%0d", i), 32'(idx[i+1] - idx[i]), 32'(exp_gap[i]));

        // BCD carry into hundreds, then saturation at 9999.
        run_cycle(0, 4'd0, 0, 1);
        run_cycle(1, 4'd0, 0, 0);
        for (int k = 0; k < 100; k++) run_cycle(0, 4'd0, 1, 0);
        run_cycle(0, 4'd0, 0, 0);
        check("score_0100", 32'(score), 32'h0100);
        for (int k = 0; k < 9905; k++) run_cycle(0, 4'd0, 1, 0);
        run_cycle(0, 4'd0, 0, 0);
        check("score_9999", 32'(score), 32'h9999);

        // Random play against the model.
        for (int k = 0; k < 3000; k++) begin
            run_cycle(($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                      ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 79) == 0));
        end

        // Reset mid-game: no clear pulse on release.
        if (m_state != 1) run_cycle(1, 4'd0, 0, 0);
        for (int k = 0; k < 5; k++) run_cycle(0, 4'd0, 1, 0);
        do_reset();
        for (int k = 0; k < 10; k++) run_cycle(0, 4'd0, 0, 0);
        for (int k = 0; k < 500; k++) begin
            run_cycle(($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 99) == 0));
        end
        run_cycle(0, 4'd0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
